// File: rtl/pot_scan_array.sv
// Multi-channel pot digitiser: one shared count ramp timestamps NUM_POTS comparator inputs.
// Optional `POT_SYNC_EN adds a 2-flop synchroniser on every pot_in channel.

module pot_scan_lane #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             sample,
    input  logic             last,
    input  logic             pot,
    input  logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] val,
    output logic             pend,
    output logic             pend_nxt
);
    logic [CNT_W-1:0] val_nxt;

    // At the terminal count, count already equals MAX_COUNT, so one latch path covers both cases
    always_comb begin
        pend_nxt = pend;
        val_nxt  = val;
        if (arm) begin
            pend_nxt = 1'b1;
        end else if (sample && pend && (pot || last)) begin
            pend_nxt = 1'b0;
            val_nxt  = count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            val  <= '0;
        end else begin
            pend <= pend_nxt;
            val  <= val_nxt;
        end
    end
endmodule

module pot_scan_array #(
    parameter int NUM_POTS    = 8,
    parameter int CNT_W       = 8,
    parameter int MAX_COUNT   = 228,
    parameter int DUMP_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      scan_tick,
    input  logic                      fast_mode,
    input  logic                      potgo,
    input  logic [NUM_POTS-1:0]       pot_in,
    output logic [NUM_POTS*CNT_W-1:0] pot_val,
    output logic [NUM_POTS-1:0]       allpot,
    output logic                      dump,
    output logic                      busy,
    output logic                      scan_done
);
    localparam int DC_W = $clog2(DUMP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DUMP, SCAN} state_t;

    state_t                           state, state_n;
    logic [CNT_W-1:0]                 count, count_n;
    logic [DC_W-1:0]                  dump_cnt, dump_cnt_n;
    logic                             done_n;
    logic                             adv, last, sample;
    logic [NUM_POTS-1:0]              pot_q, pend_nxt;
    logic [NUM_POTS-1:0][CNT_W-1:0]   val_arr;

`ifdef POT_SYNC_EN
    logic [NUM_POTS-1:0] pot_s1, pot_s2;
    always_ff @(posedge clk) begin
        if (rst) begin
            pot_s1 <= '0;
            pot_s2 <= '0;
        end else begin
            pot_s1 <= pot_in;
            pot_s2 <= pot_s1;
        end
    end
    assign pot_q = pot_s2;
`else
    assign pot_q = pot_in;
`endif

    assign adv     = fast_mode | scan_tick;
    assign last    = (count == CNT_W'(MAX_COUNT));
    // A restart in the same cycle wins over any latch
    assign sample  = (state == SCAN) && adv && !potgo;
    assign pot_val = val_arr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_POTS; gi++) begin : g_lane
            pot_scan_lane #(.CNT_W(CNT_W)) u_lane (
                .clk      (clk),
                .rst      (rst),
                .arm      (potgo),
                .sample   (sample),
                .last     (last),
                .pot      (pot_q[gi]),
                .count    (count),
                .val      (val_arr[gi]),
                .pend     (allpot[gi]),
                .pend_nxt (pend_nxt[gi])
            );
        end
    endgenerate

    always_comb begin
        state_n    = state;
        count_n    = count;
        dump_cnt_n = dump_cnt;
        done_n     = 1'b0;
        if (potgo) begin
            state_n    = DUMP;
            count_n    = '0;
            dump_cnt_n = '0;
        end else begin
            case (state)
                DUMP: begin
                    dump_cnt_n = dump_cnt + DC_W'(1);
                    if (dump_cnt == DC_W'(DUMP_CYCLES - 1)) begin
                        state_n = SCAN;
                        count_n = '0;
                    end
                end
                SCAN: begin
                    if (adv) begin
                        if (last || (pend_nxt == '0)) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            count_n = count + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            dump_cnt  <= '0;
            dump      <= 1'b1;
            busy      <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            dump_cnt  <= dump_cnt_n;
            dump      <= (state_n != SCAN);
            busy      <= (state_n != IDLE);
            scan_done <= done_n;
        end
    end
endmodule

// File: tb/tb_pot_scan_array.sv
// Directed bench for pot_scan_array; honours the 2-clk lag when POT_SYNC_EN is defined.

module tb_pot_scan_array;
`ifdef POT_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_tick = 1'b0;
    logic        fast_mode = 1'b0;
    logic        potgo = 1'b0;
    logic [7:0]  pot_in = 8'h00;
    logic [63:0] pot_val;
    logic [7:0]  allpot;
    logic        dump, busy, scan_done;

    int pass_cnt = 0;
    int total    = 0;
    int done_cnt = 0;

    pot_scan_array dut (
        .clk(clk), .rst(rst), .scan_tick(scan_tick), .fast_mode(fast_mode),
        .potgo(potgo), .pot_in(pot_in), .pot_val(pot_val), .allpot(allpot),
        .dump(dump), .busy(busy), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (scan_done === 1'b1) done_cnt++;
    endtask

    task automatic start_scan();
        potgo = 1'b1;
        tick();
        potgo = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (pot_val !== 64'h0) $display("FAIL reset_pot_val got %h want 0", pot_val); else pass_cnt++;
        total++;
        if ({allpot, dump, busy} !== {8'h00, 1'b1, 1'b0})
            $display("FAIL reset_flags got allpot=%h dump=%b busy=%b want 00/1/0", allpot, dump, busy);
        else pass_cnt++;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (done_cnt !== 0) $display("FAIL reset_idle_done got %0d want 0", done_cnt); else pass_cnt++;
    endtask

    task automatic test_fast_scan();
        int n;
        fast_mode = 1'b1;
        pot_in    = 8'h00;
        done_cnt  = 0;
        potgo = 1'b1;
        tick();
        potgo = 1'b0;
        total++;
        if ({allpot, dump, busy} !== {8'hFF, 1'b1, 1'b1})
            $display("FAIL fast_dump_entry got allpot=%h dump=%b busy=%b want FF/1/1", allpot, dump, busy);
        else pass_cnt++;
        tick();
        tick();
        total++;
        if (dump !== 1'b0) $display("FAIL fast_scan_entry dump got %b want 0", dump); else pass_cnt++;
        for (int c = 0; c <= 50; c++) begin
            if (c == 50 - LAG) pot_in[3] = 1'b1;
            tick();
        end
        total++;
        if (allpot !== 8'hF7 || pot_val[24 +: 8] !== 8'd50)
            $display("FAIL fast_latch3 got allpot=%h val=%0d want F7/50", allpot, pot_val[24 +: 8]);
        else pass_cnt++;
        pot_in[3] = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            if (n == 20) pot_in[3] = 1'b1;
            tick();
            n++;
        end
        pot_in[3] = 1'b0;
        total++;
        if (n !== 178) $display("FAIL fast_end_cycles got %0d want 178", n); else pass_cnt++;
        total++;
        if (pot_val !== {{4{8'd228}}, 8'd50, {3{8'd228}}})
            $display("FAIL fast_values got %h want e4e4e4e432e4e4e4", pot_val);
        else pass_cnt++;
        tick();
        total++;
        if (done_cnt !== 1 || scan_done !== 1'b0 || allpot !== 8'h00)
            $display("FAIL fast_done got pulses=%0d done=%b allpot=%h want 1/0/00", done_cnt, scan_done, allpot);
        else pass_cnt++;
    endtask

    task automatic test_early_finish();
        fast_mode = 1'b1;
        pot_in    = 8'hFF;
        tick();
        tick();
        tick();
        done_cnt = 0;
        start_scan();
        total++;
        if (allpot !== 8'hFF || busy !== 1'b1)
            $display("FAIL early_dump_ignore got allpot=%h busy=%b want FF/1", allpot, busy);
        else pass_cnt++;
        tick();
        total++;
        if ({busy, scan_done, allpot} !== {1'b0, 1'b1, 8'h00})
            $display("FAIL early_finish got busy=%b done=%b allpot=%h want 0/1/00", busy, scan_done, allpot);
        else pass_cnt++;
        total++;
        if (pot_val !== 64'h0) $display("FAIL early_values got %h want 0", pot_val); else pass_cnt++;
        pot_in = 8'h00;
        tick();
        total++;
        if (done_cnt !== 1 || dump !== 1'b1)
            $display("FAIL early_idle got pulses=%0d dump=%b want 1/1", done_cnt, dump);
        else pass_cnt++;
    endtask

    task automatic test_line_rate();
        fast_mode = 1'b0;
        pot_in    = 8'h00;
        start_scan();
        for (int k = 0; k <= 10; k++) begin
            tick();
            tick();
            tick();
            scan_tick = 1'b1;
            tick();
            scan_tick = 1'b0;
        end
        pot_in[0] = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (allpot !== 8'hFF) $display("FAIL line_hold got allpot=%h want FF", allpot); else pass_cnt++;
        scan_tick = 1'b1;
        tick();
        scan_tick = 1'b0;
        total++;
        if (allpot !== 8'hFE || pot_val[7:0] !== 8'd11)
            $display("FAIL line_latch0 got allpot=%h val=%0d want FE/11", allpot, pot_val[7:0]);
        else pass_cnt++;
        pot_in = 8'h00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_restart();
        int n;
        fast_mode = 1'b1;
        pot_in    = 8'h00;
        done_cnt  = 0;
        start_scan();
        for (int c = 0; c < 100; c++) begin
            if (c == 20 - LAG) pot_in[5] = 1'b1;
            tick();
        end
        pot_in[5] = 1'b0;
        potgo = 1'b1;
        tick();
        potgo = 1'b0;
        total++;
        if ({allpot, dump, busy} !== {8'hFF, 1'b1, 1'b1})
            $display("FAIL restart_entry got allpot=%h dump=%b busy=%b want FF/1/1", allpot, dump, busy);
        else pass_cnt++;
        total++;
        if (pot_val[40 +: 8] !== 8'd20) $display("FAIL restart_keep got %0d want 20", pot_val[40 +: 8]); else pass_cnt++;
        tick();
        total++;
        if (dump !== 1'b1) $display("FAIL restart_dump2 got %b want 1", dump); else pass_cnt++;
        tick();
        total++;
        if (dump !== 1'b0 || done_cnt !== 0)
            $display("FAIL restart_scan got dump=%b pulses=%0d want 0/0", dump, done_cnt);
        else pass_cnt++;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        total++;
        if (n !== 229) $display("FAIL restart_cycles got %0d want 229", n); else pass_cnt++;
        total++;
        if (done_cnt !== 1 || pot_val[40 +: 8] !== 8'd228)
            $display("FAIL restart_end got pulses=%0d val5=%0d want 1/228", done_cnt, pot_val[40 +: 8]);
        else pass_cnt++;
    endtask

    task automatic test_tie_and_abort();
        fast_mode = 1'b1;
        pot_in    = 8'h00;
        start_scan();
        for (int c = 0; c <= 228; c++) begin
            if (c == 228 - LAG) pot_in[7] = 1'b1;
            tick();
        end
        total++;
        if ({busy, scan_done, allpot} !== {1'b0, 1'b1, 8'h00} || pot_val[56 +: 8] !== 8'd228)
            $display("FAIL tie_terminal got busy=%b done=%b allpot=%h val7=%0d want 0/1/00/228",
                     busy, scan_done, allpot, pot_val[56 +: 8]);
        else pass_cnt++;
        pot_in = 8'h00;
        tick();
        start_scan();
        for (int c = 0; c < 30; c++) begin
            if (c == 10 - LAG) pot_in[1] = 1'b1;
            tick();
        end
        total++;
        if (allpot !== 8'hFD || pot_val[15:8] !== 8'd10)
            $display("FAIL abort_pre got allpot=%h val1=%0d want FD/10", allpot, pot_val[15:8]);
        else pass_cnt++;
        done_cnt = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pot_in = 8'h00;
        total++;
        if ({busy, dump, allpot} !== {1'b0, 1'b1, 8'h00} || pot_val !== 64'h0)
            $display("FAIL abort_state got busy=%b dump=%b allpot=%h val=%h want 0/1/00/0",
                     busy, dump, allpot, pot_val);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (done_cnt !== 0) $display("FAIL abort_no_done got %0d want 0", done_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fast_scan();
        test_early_finish();
        test_line_rate();
        test_restart();
        test_tie_and_abort();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/pot_scan_array.md
Name: pot_scan_array

Overview:
- Parametrised multi-channel paddle/pot digitiser for the POKEY IO block.
- Successor to the single-channel scan FSM: one shared count ramp timestamps up to NUM_POTS comparator inputs.
- Adds per-channel ALLPOT status, fast (per-clock) or line-rate (scan_tick) counting, an explicit capacitor-dump output, and POTGO restart mid-scan.
- Sits between the external pot comparators and the POKEY register read mux (POT0..POT7, ALLPOT).

Parameters:
- NUM_POTS, 8, number of pot channels.
- CNT_W, 8, width of the count and of each pot value.
- MAX_COUNT, 228, terminal count; must fit in CNT_W bits.
- DUMP_CYCLES, 2, clk cycles spent in DUMP before SCAN; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- scan_tick  in  1  one-clk count-advance strobe (line rate), used when fast_mode=0.
- fast_mode  in  1  1 = count advances every clk (SKCTL fast pot scan).
- potgo  in  1  one-clk start/restart strobe (POTGO register write).
- pot_in  in  NUM_POTS  comparator outputs; 1 = capacitor charged past threshold.
- pot_val  out  NUM_POTS*CNT_W  latched values; channel i at bits [i*CNT_W +: CNT_W].
- allpot  out  NUM_POTS  1 = channel i still scanning (not yet latched).
- dump  out  1  1 = discharge pot capacitors.
- busy  out  1  1 while in DUMP or SCAN.
- scan_done  out  1  one-clk pulse when a scan completes.

Behaviour:
- Reset values: state=IDLE, count=0, dump_cnt=0, pot_val all 0, allpot=0, dump=1, busy=0, scan_done=0. Reset mid-scan aborts immediately with no scan_done pulse.
- All outputs are registered.
- Derived signals:
  - adv = fast_mode | scan_tick.
  - dump = 1 in IDLE and DUMP, 0 in SCAN.
  - busy = (state != IDLE).
- IDLE:
  - potgo -> DUMP; on that edge dump_cnt<=0 and allpot<=all ones.
  - pot_val holds its previous values.
- DUMP:
  - dump_cnt increments every clk.
  - When dump_cnt==DUMP_CYCLES-1 -> SCAN and count<=0.
  - adv and pot_in are ignored in DUMP.
- SCAN, on a cycle with adv=1 (steps applied in this priority order):
  - For every channel i with allpot[i]=1 and pot_in[i]=1: pot_val[i]<=count, allpot[i]<=0.
  - If count==MAX_COUNT: every remaining channel with allpot[i]=1 latches MAX_COUNT and clears allpot[i]. Next state IDLE; scan_done pulses on the following cycle.
  - Else if every allpot bit is 0 after this cycle's latches: early finish -> IDLE; scan_done pulses on the following cycle.
  - Else: count<=count+1.
- SCAN, on a cycle with adv=0: no change to state, count, pot_val or allpot.
- Latching rules:
  - A channel latches at most once per scan; later pot_in toggles are ignored.
  - A channel already high at count 0 latches 0.
  - A comparator rising on the same adv cycle where count==MAX_COUNT latches MAX_COUNT.
- fast_mode may change mid-scan; it takes effect on the next cycle, and count is not reset.
- potgo during DUMP or SCAN restarts the scan: -> DUMP, dump_cnt<=0, allpot<=all ones, count<=0, no scan_done. pot_val is not cleared.
- potgo in the same cycle as scan completion: the restart wins and scan_done is suppressed.
- count never exceeds MAX_COUNT and never wraps.

Optional Feature:
- Macro POT_SYNC_EN.
- Defined: pot_in passes through a 2-flop synchroniser per channel before latch logic, adding 2 clk of latency. The bench must allow for the 2-clk lag.
- Undefined: pot_in is sampled directly by the latch logic.
- No other behaviour differs.

Test Plan:
- Reset then idle: rst=1 for 2 clk -> pot_val=0, allpot=0x00, dump=1, busy=0, scan_done never pulses.
- Fast scan, NUM_POTS=8: potgo, fast_mode=1; pot_in[3] rises on the SCAN cycle with count==50 and all other channels held 0 -> pot_val[3]=50; the other channels read 228; scan_done pulses once; allpot steps 0xFF -> 0xF7 -> 0x00.
- Early finish: all pot_in=1 before potgo -> every pot_val=0, allpot=0x00, return to IDLE 1 cycle after the first adv in SCAN, scan_done pulses.
- Line-rate scan: fast_mode=0, scan_tick every 4 clk; pot_in[0] rises just after the tick with count==10 -> pot_val[0]=11; count is unchanged between ticks.
- Restart: potgo at count==100 in SCAN -> dump=1 for DUMP_CYCLES clk, allpot=0xFF, count restarts at 0, no scan_done until the new scan ends.
- Terminal tie and reset abort: pot_in[7] rises on the count==228 adv cycle -> pot_val[7]=228. In a separate run, rst at count==30 -> IDLE, allpot=0, pot_val=0, no scan_done.
